prog_loader: RTL and testbench

- Boot/reload sequencer for the floating-point soft core.
- Receives a framed program image as a byte stream (valid/ready), writes it word by word into instruction memory, and holds the core in reset while the image is in flight.
- Releases the core only after the frame checksum verifies.
- Sits between the host byte link (UART/JTAG bridge) and the core's instruction memory write port and reset input.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/pl_word_asm.sv | 78 +++++++
 rtl/prog_loader.sv | 148 ++++++++++++++
 tb/tb_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program image loader.
// Frame layout: two length bytes, len words of NBYTE bytes each, one checksum byte.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_DATA   = 3'd4,
        ST_CHK    = 3'd5,
        ST_ERR    = 3'd6
    } pl_state_e;

    localparam int HDR_LEN = 2;
    localparam int CHK_LEN = 1;

    // Bytes needed to carry one instruction word.
    function automatic int nbyte(input int nbits);
        return (nbits + 7) / 8;
    endfunction

endpackage

// File: rtl/pl_word_asm.sv
// Word assembler: shifts data bytes in LSB first, counts bytes per word
// and keeps the running XOR of every frame byte.
module pl_word_asm
    import prog_loader_pkg::*;
#(
    parameter int NBINST = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              byte_stb_i,
    input  logic              data_stb_i,
    input  logic [7:0]        byte_i,
    output logic              word_last_o,
    output logic              word_valid_o,
    output logic [NBINST-1:0] word_o,
    output logic [7:0]        csum_o
);

    localparam int NB  = nbyte(NBINST);
    localparam int SRW = 8 * NB;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic           wv_q, wv_d;
    logic [7:0]     csum_q, csum_d;

    assign word_last_o = data_stb_i && (bcnt_q == BCW'(NB - 1));

    always_comb begin
        bcnt_d = bcnt_q;
        sr_d   = sr_q;
        wv_d   = 1'b0;
        csum_d = csum_q;
        if (clr_i) begin
            bcnt_d = '0;
            csum_d = '0;
        end else begin
            if (byte_stb_i) begin
                csum_d = csum_q ^ byte_i;
            end
            // New byte enters at the top so the first byte ends up in the LSBs.
            if (data_stb_i) begin
                sr_d   = (sr_q >> 8) | (SRW'(byte_i) << (SRW - 8));
                bcnt_d = word_last_o ? '0 : bcnt_q + BCW'(1);
            end
            wv_d = word_last_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q <= '0;
            sr_q   <= '0;
            wv_q   <= 1'b0;
            csum_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            sr_q   <= sr_d;
            wv_q   <= wv_d;
            csum_q <= csum_d;
        end
    end

    assign word_valid_o = wv_q;
    assign word_o       = sr_q[NBINST-1:0];
    assign csum_o       = csum_q;

    // Pad bits above NBINST are shifted through but never written to memory.
    generate
        if (SRW > NBINST) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^sr_q[SRW-1:NBINST];
        end
    endgenerate

endmodule

// File: rtl/prog_loader.sv
// Boot/reload sequencer: receives a framed program image, writes it into
// instruction memory and holds the core in reset until the checksum verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int NBINST     = 15,
    parameter int MINSTW     = 9,
    parameter int RUN_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_wr,
    output logic [MINSTW-1:0] im_addr,
    output logic [NBINST-1:0] im_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output pl_state_e         dbg_state
);

    localparam pl_state_e   RST_STATE = (RUN_ON_RST != 0) ? ST_RUN : ST_IDLE;
    localparam logic [16:0] MAX_LEN   = 17'(1 << MINSTW);

    pl_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [MINSTW-1:0] widx_q, widx_d;
    logic [16:0]       len_ext;

    logic              accept;
    logic              start;
    logic              word_last;
    logic              word_valid;
    logic [NBINST-1:0] word;
    logic [7:0]        csum;

    // A byte transfers on a rising edge where rx_valid && rx_ready; rx_ready
    // depends only on state, never on rx_valid, and the sender holds
    // rx_data stable while rx_valid is high and not yet accepted.
    assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign accept   = rx_valid && rx_ready;
    assign start    = load_req && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                   (state_q == ST_ERR));
    assign len_ext  = {1'b0, rx_data, len_q[7:0]};

    pl_word_asm #(
        .NBINST(NBINST)
    ) u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start),
        .byte_stb_i  (accept && (state_q != ST_CHK)),
        .data_stb_i  (accept && (state_q == ST_DATA)),
        .byte_i      (rx_data),
        .word_last_o (word_last),
        .word_valid_o(word_valid),
        .word_o      (word),
        .csum_o      (csum)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        widx_d  = widx_q;
        done    = 1'b0;
        if (word_valid) begin
            widx_d = widx_q + MINSTW'(1);
        end
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    wcnt_d  = '0;
                    widx_d  = '0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[15:8], rx_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = len_ext[15:0];
                    if (len_ext == 17'd0) begin
                        state_d = ST_CHK;
                    end else if (len_ext > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leave on the last byte so the checksum byte can follow
                // immediately; the final write lands in the first CHK cycle.
                if (word_last) begin
                    wcnt_d = wcnt_q + 16'd1;
                    if (wcnt_q == len_q - 16'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (rx_data == csum) begin
                        state_d = ST_RUN;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            len_q   <= '0;
            wcnt_q  <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            widx_q  <= widx_d;
        end
    end

    assign core_rst  = !((state_q == ST_RUN) || done);
    assign busy      = rx_ready;
    assign err       = (state_q == ST_ERR);
    assign im_wr     = word_valid;
    assign im_addr   = widx_q;
    assign im_data   = word;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames driven byte by byte, memory
// writes checked against an expected queue of {addr, data}.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int NBINST = 15;
    localparam int MINSTW = 9;
    localparam int W      = MINSTW + NBINST;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;

    logic              rx_ready, im_wr, core_rst, busy, done, err;
    logic [MINSTW-1:0] im_addr;
    logic [NBINST-1:0] im_data;
    pl_state_e         st;

    logic              rx_ready_0, im_wr_0, core_rst_0, busy_0, done_0, err_0;
    logic [MINSTW-1:0] im_addr_0;
    logic [NBINST-1:0] im_data_0;
    pl_state_e         st_0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   frame_q[$];

    prog_loader #(.NBINST(NBINST), .MINSTW(MINSTW), .RUN_ON_RST(1)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .im_wr(im_wr),
        .im_addr(im_addr), .im_data(im_data), .core_rst(core_rst),
        .busy(busy), .done(done), .err(err), .dbg_state(st)
    );

    prog_loader #(.NBINST(NBINST), .MINSTW(MINSTW), .RUN_ON_RST(0)) dut_0 (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready_0), .im_wr(im_wr_0),
        .im_addr(im_addr_0), .im_data(im_data_0), .core_rst(core_rst_0),
        .busy(busy_0), .done(done_0), .err(err_0), .dbg_state(st_0)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (done) begin
            done_cnt++;
            check_val("core_rst_on_done", 32'(core_rst), 32'd0);
        end
        if (im_wr) begin
            if (exp_q.size() == 0) begin
                check_val("im_wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("im_addr", 32'(im_addr), 32'(e[W-1:NBINST]));
                check_val("im_data", 32'(im_data), 32'(e[NBINST-1:0]));
            end
        end
    end

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            check_val("rx_ready_timeout", 32'(rx_ready), 32'd1);
        end else begin
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_all(input int gap);
        while (frame_q.size() != 0) send_byte(frame_q.pop_front(), gap);
    endtask

    task automatic frame_two(input logic [7:0] ck);
        frame_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hBC, 8'h7A, ck};
    endtask

    task automatic expect_two;
        exp_q.push_back({9'd0, 15'h1234});
        exp_q.push_back({9'd1, 15'h7ABC});
    endtask

    task automatic build_max;
        logic [7:0]  cs;
        logic [15:0] w;
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h02);
        cs = 8'h02;
        for (int i = 0; i < 512; i++) begin
            w = 16'((i * 37 + 5) & 32'h7FFF);
            frame_q.push_back(w[7:0]);
            frame_q.push_back(w[15:8]);
            cs = cs ^ w[7:0] ^ w[15:8];
            exp_q.push_back({9'(i), w[14:0]});
        end
        frame_q.push_back(cs);
    endtask

    task automatic check_started(input string tag);
        check_val({tag, "_state"}, 32'(st), 32'(ST_LEN_LO));
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic check_run(input string tag, input int d0);
        check_val({tag, "_state"}, 32'(st), 32'(ST_RUN));
        check_val({tag, "_core_rst"}, 32'(core_rst), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
        check_val({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string tag, input int d0);
        check_val({tag, "_state"}, 32'(st), 32'(ST_ERR));
        check_val({tag, "_err"}, 32'(err), 32'd1);
        check_val({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check_val({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] b;

        // reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_state", 32'(st), 32'(ST_RUN));
        check_val("rst_core_rst", 32'(core_rst), 32'd0);
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_im_wr", 32'(im_wr), 32'd0);
        check_val("rst_im_addr", 32'(im_addr), 32'd0);
        check_val("rst_im_data", 32'(im_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst0_state", 32'(st_0), 32'(ST_IDLE));
        check_val("rst0_core_rst", 32'(core_rst_0), 32'd1);

        // two-word load, back-to-back bytes
        d0 = done_cnt;
        pulse_load();
        check_started("two_start");
        check_val("two_rx_ready", 32'(rx_ready), 32'd1);
        expect_two();
        frame_two(8'hE2);
        send_all(0);
        check_run("two", d0);
        check_val("two_done_low", 32'(done), 32'd0);

        // bad checksum, then recovery
        d0 = done_cnt;
        pulse_load();
        expect_two();
        frame_two(8'hE3);
        send_all(0);
        check_err("badck", d0);
        check_val("badck_pending", 32'(exp_q.size()), 32'd0);
        pulse_load();
        check_started("recover_start");
        d0 = done_cnt;
        expect_two();
        frame_two(8'hE2);
        send_all(0);
        check_run("recover", d0);

        // zero-length frame
        d0 = done_cnt;
        pulse_load();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_all(0);
        check_run("zero", d0);

        // length 0x0201 exceeds memory
        d0 = done_cnt;
        pulse_load();
        frame_q = '{8'h01, 8'h02};
        send_all(0);
        check_err("toolong", d0);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        check_val("toolong_hold_state", 32'(st), 32'(ST_ERR));
        check_val("toolong_hold_rx_ready", 32'(rx_ready), 32'd0);

        // maximum length 512 words, address wraps after the final write
        pulse_load();
        d0 = done_cnt;
        build_max();
        send_all(0);
        check_run("max", d0);
        check_val("max_addr_wrap", 32'(im_addr), 32'd0);

        // gapped bytes with a stray load_req mid-frame
        pulse_load();
        d0 = done_cnt;
        expect_two();
        frame_two(8'hE2);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                pulse_load();
                check_val("gap_ignored_state", 32'(st), 32'(ST_DATA));
            end
            b = frame_q.pop_front();
            send_byte(b, 2);
            if (i < 6) check_val($sformatf("gap_busy_%0d", i), 32'(busy), 32'd1);
        end
        check_run("gap", d0);

        // reset after four data bytes abandons the frame
        pulse_load();
        expect_two();
        frame_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hBC, 8'h7A};
        send_all(0);
        rst = 1'b1;
        tick();
        check_val("midrst_state", 32'(st), 32'(ST_RUN));
        check_val("midrst_core_rst", 32'(core_rst), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_im_wr", 32'(im_wr), 32'd0);
        check_val("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("midrst0_state", 32'(st_0), 32'(ST_IDLE));
        check_val("midrst0_core_rst", 32'(core_rst_0), 32'd1);
        rst = 1'b0;
        repeat (4) tick();
        check_val("final_pending", 32'(exp_q.size()), 32'd0);

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
